// File: rtl/dbg_trace_buffer.sv
// Per-lane debug event recorder: circular trace RAM with code-match trigger,
// post-trigger capture window and oldest-first valid/ready readout.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | nothing armed, no trace held
// ARMED | recording into the ring, watching lanes for a trigger hit
// POST  | trigger seen, recording post_len more entries
// DONE  | trace frozen, readout port active
module dbg_trace_buffer #(
   parameter int NUM_LANES = 2,
   parameter int CODE_W    = 4,
   parameter int DEPTH     = 16,
   parameter int TS_W      = 16,
   parameter int REC_IDLE  = 0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_LANES-1:0]                 lane_valid,
   input  logic [NUM_LANES*CODE_W-1:0]          lane_code,
   input  logic                                 arm,
   input  logic                                 abort,
   input  logic [CODE_W-1:0]                    trig_code,
   input  logic [CODE_W-1:0]                    trig_mask,
   input  logic [NUM_LANES-1:0]                 trig_lane_en,
   input  logic [$clog2(DEPTH):0]               post_len,
   output logic [1:0]                           state,
   output logic                                 triggered,
   output logic [$clog2(DEPTH):0]               entries,
   output logic [$clog2(DEPTH)-1:0]             trig_idx,
   output logic                                 rd_valid,
   input  logic                                 rd_ready,
   output logic [TS_W+NUM_LANES*(1+CODE_W)-1:0] rd_data,
   output logic                                 rd_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TS_W + NUM_LANES * (1 + CODE_W);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_ARMED = 2'b01;
   localparam logic [1:0] S_POST  = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [TS_W-1:0] ts;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   rd_cnt;
   logic [CW-1:0]   post_cnt;
   logic [EW-1:0]   ram [DEPTH];

   logic            hit_any;
   logic            hit;
   logic            rec;
   logic            full;
   logic [AW-1:0]   oldest;
   logic [AW-1:0]   rd_addr;

   always_comb begin
      hit_any = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_valid[i] && trig_lane_en[i] &&
             (((lane_code[i*CODE_W +: CODE_W] ^ trig_code) & trig_mask) == '0))
            hit_any = 1'b1;
      end
   end

   assign hit     = (state == S_ARMED) && hit_any;
   assign rec     = ((state == S_ARMED) || (state == S_POST)) &&
                    ((|lane_valid) || (REC_IDLE != 0));
   assign full    = (entries == FULL_CNT);
   assign oldest  = full ? wr_ptr : '0;
   // Readout address is derived from the read count so it always starts at the oldest entry.
   assign rd_addr = oldest + rd_cnt[AW-1:0];
   assign rd_valid = (state == S_DONE) && (rd_cnt < entries);
   assign rd_last  = rd_valid && (rd_cnt == entries - 1'b1);
   assign rd_data  = rd_valid ? ram[rd_addr] : '0;

   always_ff @(posedge clk) begin
      if (rec)
         ram[wr_ptr] <= {ts, lane_valid, lane_code};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ts <= '0;
      else
         ts <= ts + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         triggered <= 1'b0;
         entries   <= '0;
         trig_idx  <= '0;
         wr_ptr    <= '0;
         rd_cnt    <= '0;
         post_cnt  <= '0;
      end else begin
         if (rec) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full)
               entries <= entries + 1'b1;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state     <= S_ARMED;
                  wr_ptr    <= '0;
                  entries   <= '0;
                  triggered <= 1'b0;
                  trig_idx  <= '0;
                  rd_cnt    <= '0;
               end else if (rd_valid && rd_ready) begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            S_ARMED: begin
               if (hit) begin
                  triggered <= 1'b1;
                  trig_idx  <= full ? {AW{1'b1}} : wr_ptr;
                  post_cnt  <= post_len;
                  if (abort || (post_len == '0))
                     state <= S_DONE;
                  else
                     state <= S_POST;
               end else if (abort) begin
                  state <= S_DONE;
               end
            end
            S_POST: begin
               if (rec) begin
                  post_cnt <= post_cnt - 1'b1;
                  // Overwriting the oldest slot shifts the trigger one place closer; once it is gone it pins at 0.
                  if (full && (trig_idx != '0))
                     trig_idx <= trig_idx - 1'b1;
                  if (post_cnt == CW'(1))
                     state <= S_DONE;
               end
               if (abort)
                  state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Directed, table-driven bench for dbg_trace_buffer (2 lanes, 4-bit codes, 8-entry ring).
module tb_dbg_trace_buffer;

   localparam int NL   = 2;
   localparam int CWD  = 4;
   localparam int DEP  = 8;
   localparam int TSW  = 16;
   localparam int EW   = TSW + NL * (1 + CWD);

   logic             clk;
   logic             rst_n;
   logic [NL-1:0]    lane_valid;
   logic [NL*CWD-1:0] lane_code;
   logic             arm;
   logic             abort;
   logic [CWD-1:0]   trig_code;
   logic [CWD-1:0]   trig_mask;
   logic [NL-1:0]    trig_lane_en;
   logic [3:0]       post_len;
   logic [1:0]       state;
   logic             triggered;
   logic [3:0]       entries;
   logic [2:0]       trig_idx;
   logic             rd_valid;
   logic             rd_ready;
   logic [EW-1:0]    rd_data;
   logic             rd_last;

   dbg_trace_buffer #(
      .NUM_LANES(NL), .CODE_W(CWD), .DEPTH(DEP), .TS_W(TSW), .REC_IDLE(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .lane_valid(lane_valid), .lane_code(lane_code),
      .arm(arm), .abort(abort), .trig_code(trig_code), .trig_mask(trig_mask),
      .trig_lane_en(trig_lane_en), .post_len(post_len), .state(state),
      .triggered(triggered), .entries(entries), .trig_idx(trig_idx),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference free-running timestamp: cycles since reset release.
   logic [TSW-1:0] tb_ts;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_ts <= '0;
      else        tb_ts <= tb_ts + 1'b1;
   end

   typedef struct {
      logic [1:0] valid;
      logic [7:0] code;
      logic       arm;
      logic       abort;
      logic       rec;
      logic [1:0] exp_state;
      logic [3:0] exp_entries;
      logic       exp_trig;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] v, input logic [7:0] c, input logic a,
                               input logic ab, input logic r, input logic [1:0] s,
                               input logic [3:0] e, input logic tr);
      vec_t x;
      x.valid = v; x.code = c; x.arm = a; x.abort = ab; x.rec = r;
      x.exp_state = s; x.exp_entries = e; x.exp_trig = tr;
      return x;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      lane_valid = v.valid;
      lane_code  = v.code;
      arm        = v.arm;
      abort      = v.abort;
      if (v.rec) exp_q.push_back({tb_ts, v.valid, v.code});
      @(posedge clk); #1;
      arm   = 1'b0;
      abort = 1'b0;
      chk({tag, "_state"},     state,     v.exp_state);
      chk({tag, "_entries"},   entries,   v.exp_entries);
      chk({tag, "_triggered"}, triggered, v.exp_trig);
   endtask

   task automatic read_out(input int n, input bit toggle, input string tag);
      int k = 0;
      int base = exp_q.size() - n;
      bit hs;
      for (int c = 0; c < 4 * n + 8 && k < n; c++) begin
         rd_ready = toggle ? (c % 2 == 0) : 1'b1;
         chk({tag, "_rd_valid"}, rd_valid, 1'b1);
         chk({tag, "_rd_data"},  rd_data,  exp_q[base + k]);
         chk({tag, "_rd_last"},  rd_last,  (k == n - 1));
         hs = rd_ready && rd_valid;
         @(posedge clk); #1;
         if (hs) k++;
      end
      rd_ready = 1'b0;
      chk({tag, "_rd_count"}, k, n);
      chk({tag, "_rd_valid_end"}, rd_valid, 1'b0);
   endtask

   vec_t t1[8];
   vec_t t3[8];

   initial begin
      // Basic capture: three pre-trigger entries, hit on lane1, two post entries.
      t1[0] = mk(2'b00, 8'h00, 1, 0, 0, 2'd1, 4'd0, 0);
      t1[1] = mk(2'b11, 8'h21, 0, 0, 1, 2'd1, 4'd1, 0);
      t1[2] = mk(2'b11, 8'h21, 0, 0, 1, 2'd1, 4'd2, 0);
      t1[3] = mk(2'b11, 8'h21, 0, 0, 1, 2'd1, 4'd3, 0);
      t1[4] = mk(2'b11, 8'h51, 0, 0, 1, 2'd2, 4'd4, 1);
      t1[5] = mk(2'b11, 8'h25, 0, 0, 1, 2'd2, 4'd5, 1);
      t1[6] = mk(2'b01, 8'h53, 0, 0, 1, 2'd3, 4'd6, 1);
      t1[7] = mk(2'b11, 8'h55, 0, 0, 0, 2'd3, 4'd6, 1);
      // Idle cycles skipped, then abort without a hit.
      t3[0] = mk(2'b00, 8'h00, 1, 0, 0, 2'd1, 4'd0, 0);
      t3[1] = mk(2'b01, 8'h05, 0, 0, 1, 2'd1, 4'd1, 0);
      t3[2] = mk(2'b00, 8'h00, 0, 0, 0, 2'd1, 4'd1, 0);
      t3[3] = mk(2'b10, 8'h70, 0, 0, 1, 2'd1, 4'd2, 0);
      t3[4] = mk(2'b00, 8'h00, 0, 0, 0, 2'd1, 4'd2, 0);
      t3[5] = mk(2'b00, 8'h00, 0, 0, 0, 2'd1, 4'd2, 0);
      t3[6] = mk(2'b11, 8'h39, 0, 0, 1, 2'd1, 4'd3, 0);
      t3[7] = mk(2'b00, 8'h00, 0, 1, 0, 2'd3, 4'd3, 0);

      rst_n = 1'b0; lane_valid = '0; lane_code = '0; arm = 0; abort = 0;
      trig_code = 4'h5; trig_mask = 4'hF; trig_lane_en = 2'b11; post_len = 4'd2;
      rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state, 2'd0);
      chk("rst_triggered", triggered, 1'b0);
      chk("rst_entries", entries, 4'd0);
      chk("rst_trig_idx", trig_idx, 3'd0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_rd_last", rd_last, 1'b0);
      rst_n = 1'b1;

      exp_q.delete();
      for (int i = 0; i < 8; i++) apply(t1[i], $sformatf("basic%0d", i));
      chk("basic_trig_idx", trig_idx, 3'd3);
      read_out(6, 1'b0, "basic_rd");

      // Wrap: 20 non-matching entries, then a hit with no post window.
      exp_q.delete();
      post_len = 4'd0;
      apply(mk(2'b00, 8'h00, 1, 0, 0, 2'd1, 4'd0, 0), "wrap_arm");
      for (int i = 0; i < 20; i++)
         apply(mk(2'b01, {4'h0, 4'(i % 4)}, 0, 0, 1, 2'd1, (i + 1 < 8) ? 4'(i + 1) : 4'd8, 0),
               $sformatf("wrap%0d", i));
      apply(mk(2'b01, 8'h05, 0, 0, 1, 2'd3, 4'd8, 1), "wrap_hit");
      chk("wrap_trig_idx", trig_idx, 3'd7);
      chk("wrap_oldest", rd_data, exp_q[13]);
      read_out(8, 1'b0, "wrap_rd");

      // Idle gaps and abort with no hit, read out under backpressure.
      exp_q.delete();
      trig_lane_en = 2'b00;
      for (int i = 0; i < 8; i++) apply(t3[i], $sformatf("idle%0d", i));
      chk("idle_gap_ts", exp_q[1][EW-1 -: TSW] - exp_q[0][EW-1 -: TSW], 16'd2);
      read_out(3, 1'b1, "idle_rd");

      // Abort and hit in the same cycle, mask 0 matching any enabled lane.
      exp_q.delete();
      trig_mask = 4'h0; trig_lane_en = 2'b01; post_len = 4'd3;
      apply(mk(2'b00, 8'h00, 1, 0, 0, 2'd1, 4'd0, 0), "abhit_arm");
      apply(mk(2'b10, 8'h30, 0, 0, 1, 2'd1, 4'd1, 0), "abhit_pre");
      apply(mk(2'b01, 8'h0A, 0, 1, 1, 2'd3, 4'd2, 1), "abhit_hit");
      chk("abhit_trig_idx", trig_idx, 3'd1);
      chk("midrd_first", rd_data, exp_q[0]);
      rd_ready = 1'b1;
      @(posedge clk); #1;
      chk("midrd_second", rd_data, exp_q[1]);
      chk("midrd_second_last", rd_last, 1'b1);
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0; rd_ready = 1'b0;
      chk("midrd_state", state, 2'd1);
      chk("midrd_rd_valid", rd_valid, 1'b0);
      chk("midrd_entries", entries, 4'd0);

      // Asynchronous reset in the middle of a post-trigger window.
      trig_mask = 4'hF; trig_lane_en = 2'b11; post_len = 4'd5;
      apply(mk(2'b01, 8'h05, 0, 0, 1, 2'd2, 4'd1, 1), "rstpost_hit");
      apply(mk(2'b01, 8'h01, 0, 0, 1, 2'd2, 4'd2, 1), "rstpost_rec");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state, 2'd0);
      chk("arst_triggered", triggered, 1'b0);
      chk("arst_entries", entries, 4'd0);
      chk("arst_trig_idx", trig_idx, 3'd0);
      chk("arst_rd_valid", rd_valid, 1'b0);
      chk("arst_rd_data", rd_data, '0);
      lane_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      apply(mk(2'b00, 8'h00, 1, 0, 0, 2'd1, 4'd0, 0), "rerun_arm");
      apply(mk(2'b01, 8'h01, 0, 0, 1, 2'd1, 4'd1, 0), "rerun_rec");
      apply(mk(2'b00, 8'h00, 0, 1, 0, 2'd3, 4'd1, 0), "rerun_abort");
      chk("rerun_ts", rd_data[EW-1 -: TSW], 16'd1);
      read_out(1, 1'b0, "rerun_rd");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/dbg_trace_buffer.md
Name: dbg_trace_buffer

Overview:
- Per-lane debug event recorder for the superscalar pipeline.
- Each cycle it samples NUM_LANES enum-encoded codes (instruction type, hazard signal or ALU op, each CODE_W wide) with a timestamp into a circular trace RAM.
- A programmable code match triggers it; it then records a programmable number of post-trigger entries and freezes.
- The frozen trace is read out oldest-first over a valid/ready port for waveform/bench inspection.

Parameters:
- NUM_LANES, 2, issue lanes sampled per cycle (>=1)
- CODE_W, 4, width of each lane code (matches 4-bit instruction/control/hazard enums; 5 for ALU ops)
- DEPTH, 16, trace entries; power of two, >=2
- TS_W, 16, timestamp width
- REC_IDLE, 0, 1 = record cycles with no valid lane; 0 = skip them

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lane_valid  in  NUM_LANES  per-lane sample valid
- lane_code  in  NUM_LANES*CODE_W  lane i code at [i*CODE_W +: CODE_W]
- arm  in  1  pulse: clear buffer, start recording
- abort  in  1  pulse: stop recording immediately
- trig_code  in  CODE_W  trigger compare value
- trig_mask  in  CODE_W  compare bit mask (1 = bit compared)
- trig_lane_en  in  NUM_LANES  lanes allowed to trigger
- post_len  in  $clog2(DEPTH)+1  entries to record after the trigger entry
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
- triggered  out  1  trigger occurred in this capture
- entries  out  $clog2(DEPTH)+1  valid entries held (saturates at DEPTH)
- trig_idx  out  $clog2(DEPTH)  trigger entry offset from oldest entry
- rd_valid  out  1  readout entry available
- rd_ready  in  1  consumer accepts entry
- rd_data  out  TS_W+NUM_LANES*(1+CODE_W)  {timestamp, lane_valid, lane_code}
- rd_last  out  1  rd_data is newest entry

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; triggered=0; entries=0; trig_idx=0; rd_valid=0; rd_last=0; rd_data=0.
  - Timestamp, wr_ptr, rd_ptr and post counter all 0. RAM contents are don't-care.
  - Reset mid-capture or mid-readout discards everything.
- Timestamp: free-running counter, +1 every cycle from reset, wraps modulo 2^TS_W, independent of state.
- Record condition: state in {ARMED, POST} and (|lane_valid or REC_IDLE).
- Recording:
  - Writes {ts, lane_valid, lane_code} at wr_ptr; wr_ptr+1 mod DEPTH.
  - entries+1, saturating at DEPTH.
  - Once full, the oldest entry is overwritten; oldest = wr_ptr when entries==DEPTH, else 0.
- Trigger hit: state==ARMED and, for some lane i, lane_valid[i] & trig_lane_en[i] & (((lane_code_i ^ trig_code) & trig_mask)==0).
  - trig_mask=0 matches any valid enabled lane.
- Transitions:
  - IDLE/DONE + arm -> ARMED. Clears wr_ptr, entries, triggered, trig_idx and the readout pointer. Sample on the arm cycle is not recorded.
  - ARMED + hit -> records the hit cycle's entry; triggered=1; trig_idx latched as that entry's offset from the oldest entry after the write. Then -> DONE if post_len==0, else -> POST with counter=post_len.
  - POST: each recorded entry decrements the counter; the entry that takes it to 0 -> DONE. Further hits ignored. post_len sampled only at trigger time.
  - ARMED/POST + abort -> DONE; triggered unchanged.
  - abort + hit in the same ARMED cycle -> entry recorded, triggered=1, DONE.
  - abort in IDLE/DONE: no effect. arm in ARMED/POST: ignored; abort has priority.
  - When post_len >= DEPTH, the trigger entry may be overwritten; trig_idx is then reported as 0.
- Readout (DONE only):
  - rd_valid=1 while unread entries remain; rd_data combinationally from RAM at rd_ptr, starting at the oldest entry.
  - rd_valid&rd_ready advances rd_ptr mod DEPTH. rd_last=1 on the entries-th entry.
  - After the last handshake rd_valid=0 until the next arm.
  - rd_data stable while rd_valid&!rd_ready. entries==0 in DONE -> rd_valid stays 0.
  - arm during readout aborts readout and rearms the same cycle.

Test Plan:
- NUM_LANES=2, CODE_W=4, DEPTH=8, post_len=2, trig_code=4'h5, mask=F, lane_en=11: reset, arm, 3 cycles of both lanes valid with codes 1/2, then lane1=5 -> POST, 2 more entries, DONE. entries=6, triggered=1, trig_idx=3. Readout gives 6 entries with ascending ts, rd_last on the 6th.
- Wrap: 20 valid cycles in ARMED, then hit with post_len=0 -> entries=8, oldest entry is the 14th recorded, trig_idx=7.
- REC_IDLE=0, 4 idle cycles interleaved with valids -> no idle entries; timestamps show the gaps.
- abort after 3 entries, no hit -> DONE, triggered=0, entries=3. abort+hit same cycle -> entry recorded, triggered=1.
- Backpressure: rd_ready toggled 1/0 each cycle -> each entry held stable, none lost or duplicated. arm mid-readout -> rd_valid=0, state=ARMED next cycle.
- rst_n low mid-POST -> all outputs 0, state=IDLE immediately (async). Timestamp restarts at 0.
